// File: rtl/boot_pkg.sv
// Shared definitions for the instruction-memory boot loader.
// State encoding and stream framing constants.
package boot_pkg;

    typedef enum logic [2:0] {
        LEN_HI = 3'd0,
        LEN_LO = 3'd1,
        WORD   = 3'd2,
        CHK    = 3'd3,
        RUN    = 3'd4,
        ERR    = 3'd5
    } boot_state_t;

    localparam int        LEN_BYTES      = 2;
    localparam int        BYTES_PER_WORD = 4;
    localparam logic [7:0] CHK_INIT      = 8'h00;

    function automatic logic accepts_bytes(input boot_state_t s);
        return (s == LEN_HI) || (s == LEN_LO) || (s == WORD) || (s == CHK);
    endfunction

endpackage

// File: rtl/byte_word_packer.sv
// Packs a big-endian byte stream into 32-bit words.
// o_word_valid pulses the cycle after the 4th byte of a word.
module byte_word_packer
    import boot_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [1:0]  o_cnt,
    output logic        o_word_valid,
    output logic [31:0] o_word
);

    logic [1:0]  r_cnt;
    logic        r_word_valid;
    logic [31:0] r_shift;
    logic        w_last;

    assign w_last = (r_cnt == 2'(BYTES_PER_WORD - 1));

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cnt        <= 2'd0;
            r_word_valid <= 1'b0;
            r_shift      <= 32'd0;
        end else begin
            r_word_valid <= i_en && w_last;
            if (i_en) begin
                r_cnt   <= r_cnt + 2'd1;
                r_shift <= {r_shift[23:0], i_byte};
            end
        end
    end

    assign o_cnt        = r_cnt;
    assign o_word_valid = r_word_valid;
    assign o_word       = r_shift;

endmodule

// File: rtl/imem_boot_loader.sv
// Byte-stream boot loader: length header, payload words, XOR checksum,
// then a single core_start pulse releasing the core from PC=0.
module imem_boot_loader
    import boot_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk1,
    input  logic              rst,
    input  logic [7:0]        s_byte,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_halt,
    output logic              core_start,
    output logic              busy,
    output logic              done,
    output logic              err
);

    boot_state_t       r_state;
    logic [15:0]       r_len;
    logic [ADDR_W-1:0] r_widx;
    logic [7:0]        r_chk;
    logic              r_s_ready;
    logic              r_busy;
    logic              r_halt;
    logic              r_start;
    logic              r_done;
    logic              r_err;

    logic              w_xfer;
    logic              w_pack_en;
    logic [1:0]        w_pk_cnt;
    logic              w_wr;
    logic [31:0]       w_word;
    logic [15:0]       w_len;
    logic              w_len_bad;
    logic              w_last_idx;
    logic              w_word_end;

    assign w_xfer     = s_valid && r_s_ready;
    assign w_pack_en  = w_xfer && (r_state == WORD);
    assign w_len      = {r_len[15:8], s_byte};
    assign w_len_bad  = (w_len == 16'd0) ||
                        ({1'b0, w_len} > 17'(MAX_WORDS));
    assign w_last_idx = (16'(r_widx) == (r_len - 16'd1));
    assign w_word_end = w_pack_en &&
                        (w_pk_cnt == 2'(BYTES_PER_WORD - 1));

    byte_word_packer u_packer (
        .i_clk        (clk1),
        .i_clr        (rst),
        .i_en         (w_pack_en),
        .i_byte       (s_byte),
        .o_cnt        (w_pk_cnt),
        .o_word_valid (w_wr),
        .o_word       (w_word)
    );

    always_ff @(posedge clk1) begin
        if (rst) begin
            r_state   <= LEN_HI;
            r_len     <= 16'd0;
            r_widx    <= '0;
            r_chk     <= CHK_INIT;
            r_s_ready <= 1'b0;
            r_busy    <= 1'b0;
            r_halt    <= 1'b1;
            r_start   <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_start <= 1'b0;
            // Index stays on N-1 after the final write.
            if (w_wr && !w_last_idx) begin
                r_widx <= r_widx + 1'b1;
            end
            unique case (r_state)
                LEN_HI: begin
                    r_s_ready <= 1'b1;
                    if (w_xfer) begin
                        r_len[15:8] <= s_byte;
                        r_busy      <= 1'b1;
                        r_state     <= LEN_LO;
                    end
                end
                LEN_LO: begin
                    if (w_xfer) begin
                        r_len[7:0] <= s_byte;
                        if (w_len_bad) begin
                            r_state   <= ERR;
                            r_err     <= 1'b1;
                            r_busy    <= 1'b0;
                            r_s_ready <= 1'b0;
                        end else begin
                            r_state <= WORD;
                        end
                    end
                end
                WORD: begin
                    if (w_pack_en) begin
                        r_chk <= r_chk ^ s_byte;
                    end
                    if (w_word_end && w_last_idx) begin
                        r_state <= CHK;
                    end
                end
                CHK: begin
                    if (w_xfer) begin
                        r_busy    <= 1'b0;
                        r_s_ready <= 1'b0;
                        if (s_byte == r_chk) begin
                            r_state <= RUN;
                            r_done  <= 1'b1;
                            r_start <= 1'b1;
                            r_halt  <= 1'b0;
                        end else begin
                            r_state <= ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_s_ready <= 1'b0;
                end
                ERR: begin
                    r_s_ready <= 1'b0;
                end
                default: begin
                    r_state   <= ERR;
                    r_err     <= 1'b1;
                    r_busy    <= 1'b0;
                    r_s_ready <= 1'b0;
                end
            endcase
        end
    end

    assign s_ready    = r_s_ready;
    assign mem_we     = w_wr;
    assign mem_addr   = r_widx;
    assign mem_wdata  = w_word;
    assign core_halt  = r_halt;
    assign core_start = r_start;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Directed table-driven bench for imem_boot_loader.
module tb_imem_boot_loader;

    logic        clk1 = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  s_byte = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_halt;
    logic        core_start;
    logic        busy;
    logic        done;
    logic        err;

    imem_boot_loader #(.ADDR_W(10), .MAX_WORDS(1024)) dut (
        .clk1       (clk1),
        .rst        (rst),
        .s_byte     (s_byte),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .core_halt  (core_halt),
        .core_start (core_start),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    always #5 clk1 = ~clk1;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    // Write / start recorder
    int          nwr = 0;
    int          starts = 0;
    int          start_cyc = -1;
    logic [9:0]  wr_addr [1100];
    logic [31:0] wr_data [1100];
    int          wr_cyc  [1100];
    int          xfer_cyc;

    always @(negedge clk1) begin
        if (mem_we) begin
            if (nwr < 1100) begin
                wr_addr[nwr] = mem_addr;
                wr_data[nwr] = mem_wdata;
                wr_cyc[nwr]  = cyc;
            end
            nwr = nwr + 1;
        end
        if (core_start) begin
            starts    = starts + 1;
            start_cyc = cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic clear_rec();
        nwr       = 0;
        starts    = 0;
        start_cyc = -1;
    endtask

    task automatic do_reset();
        @(negedge clk1);
        rst     = 1'b1;
        s_valid = 1'b0;
        @(negedge clk1);
        @(negedge clk1);
        rst = 1'b0;
        clear_rec();
    endtask

    // Called on a negedge; returns on the negedge after the transfer.
    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        if (gap) begin
            s_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk1);
        end
        s_valid = 1'b1;
        s_byte  = b;
        t = 0;
        while (!s_ready && t < 50) begin
            @(negedge clk1);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: s_ready=%b want 1", s_ready);
        end
        @(negedge clk1);
        xfer_cyc = cyc;
        s_valid  = 1'b0;
    endtask

    typedef struct {
        logic [95:0] bytes;
        int          n;
        bit          gap;
        int          nwr;
        logic [31:0] w0;
        logic [31:0] w1;
        bit          done;
        bit          err;
    } vec_t;

    vec_t vecs [6];
    int   pay_cyc;
    int   chk_cyc;
    logic [7:0] xs;

    initial begin
        vecs[0] = '{{8'h00,8'h02,8'h28,8'h01,8'h00,8'h0a,
                     8'hfc,8'h00,8'h00,8'h00,8'hDF,8'h00},
                    11, 0, 2, 32'h2801000a, 32'hfc000000, 1, 0};
        vecs[1] = '{{8'h00,8'h02,8'h28,8'h01,8'h00,8'h0a,
                     8'hfc,8'h00,8'h00,8'h00,8'hDE,8'h00},
                    11, 0, 2, 32'h2801000a, 32'hfc000000, 0, 1};
        vecs[2] = '{{8'h00,8'h00,80'h0}, 2, 0, 0, 0, 0, 0, 1};
        vecs[3] = '{{8'h04,8'h01,80'h0}, 2, 0, 0, 0, 0, 0, 1};
        vecs[4] = '{{8'h00,8'h02,8'h28,8'h01,8'h00,8'h0a,
                     8'hfc,8'h00,8'h00,8'h00,8'hDF,8'h00},
                    11, 1, 2, 32'h2801000a, 32'hfc000000, 1, 0};
        vecs[5] = '{{8'h00,8'h01,8'h12,8'h34,8'h56,8'h78,
                     8'h08,40'h0},
                    7, 0, 1, 32'h12345678, 0, 1, 0};

        do_reset();
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_mem", {mem_we, 21'd0, mem_addr}, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_flags", {core_halt, core_start, busy, done, err},
              32'b10000);

        for (int v = 0; v < 6; v++) begin
            do_reset();
            pay_cyc = -1;
            chk_cyc = -1;
            for (int i = 0; i < vecs[v].n; i++) begin
                send_byte(vecs[v].bytes[95-8*i -: 8], vecs[v].gap);
                if (i == vecs[v].n - 2) pay_cyc = xfer_cyc;
                if (i == vecs[v].n - 1) chk_cyc = xfer_cyc;
            end
            repeat (3) @(negedge clk1);
            check($sformatf("v%0d_nwr", v), nwr, vecs[v].nwr);
            if (vecs[v].nwr > 0) begin
                check($sformatf("v%0d_a0", v), 32'(wr_addr[0]), 0);
                check($sformatf("v%0d_d0", v), wr_data[0], vecs[v].w0);
            end
            if (vecs[v].nwr > 1) begin
                check($sformatf("v%0d_a1", v), 32'(wr_addr[1]), 1);
                check($sformatf("v%0d_d1", v), wr_data[1], vecs[v].w1);
                check($sformatf("v%0d_wr_lat", v), wr_cyc[1], pay_cyc);
            end
            check($sformatf("v%0d_done", v), 32'(done), 32'(vecs[v].done));
            check($sformatf("v%0d_err", v), 32'(err), 32'(vecs[v].err));
            check($sformatf("v%0d_halt", v), 32'(core_halt),
                  32'(!vecs[v].done));
            check($sformatf("v%0d_starts", v), starts, 32'(vecs[v].done));
            if (vecs[v].done)
                check($sformatf("v%0d_start_lat", v), start_cyc, chk_cyc);
            check($sformatf("v%0d_busy", v), 32'(busy), 0);
            // Bytes after a terminal state must be ignored.
            s_valid = 1'b1;
            s_byte  = 8'h55;
            repeat (4) begin
                @(negedge clk1);
                check($sformatf("v%0d_term_ready", v), 32'(s_ready), 0);
            end
            s_valid = 1'b0;
            check($sformatf("v%0d_term_nwr", v), nwr, vecs[v].nwr);
        end

        // Header 04 00 is the largest legal length.
        do_reset();
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        check("len1024_busy", 32'(busy), 1);
        check("len1024_err", 32'(err), 0);
        check("len1024_ready", 32'(s_ready), 1);

        // Reset after 5 payload bytes, then a full stream.
        do_reset();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h28, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h0a, 0);
        send_byte(8'hfc, 0);
        do_reset();
        check("midrst_addr", 32'(mem_addr), 0);
        check("midrst_busy", 32'(busy), 0);
        for (int i = 0; i < 11; i++)
            send_byte(vecs[0].bytes[95-8*i -: 8], 0);
        repeat (3) @(negedge clk1);
        check("midrst_nwr", nwr, 2);
        check("midrst_a0", 32'(wr_addr[0]), 0);
        check("midrst_d0", wr_data[0], 32'h2801000a);
        check("midrst_d1", wr_data[1], 32'hfc000000);
        check("midrst_done", 32'(done), 1);
        check("midrst_starts", starts, 1);

        // Max-size program: word i holds value i.
        do_reset();
        xs = 8'h00;
        send_byte(8'h04, 0);
        send_byte(8'h00, 0);
        for (int w = 0; w < 1024; w++) begin
            for (int k = 3; k >= 0; k--) begin
                logic [31:0] wv;
                wv = 32'(w);
                xs = xs ^ wv[8*k +: 8];
                send_byte(wv[8*k +: 8], 0);
            end
        end
        send_byte(xs, 0);
        repeat (3) @(negedge clk1);
        check("max_nwr", nwr, 1024);
        begin
            int bad;
            bad = 0;
            for (int w = 0; w < 1024; w++)
                if (wr_addr[w] != 10'(w) || wr_data[w] != 32'(w)) bad++;
            check("max_seq", bad, 0);
        end
        check("max_last_addr", 32'(wr_addr[1023]), 1023);
        check("max_done", 32'(done), 1);
        check("max_starts", starts, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
Name: imem_boot_loader

Overview:
- Upstream stage of pipe_MIPS32. Receives a program as a byte stream on a valid/ready link and packs it into 32-bit big-endian instruction words.
- Writes the words into instruction memory from address 0 upward and verifies an XOR checksum.
- Holds the core halted during the load, then issues a single start pulse so the core runs from PC=0.
- Replaces hierarchical memory preloading with a synthesizable boot path.

Parameters:
- ADDR_W, 10, instruction memory word-address width.
- MAX_WORDS, 1024, largest accepted program length in words; must be ≤ 2**ADDR_W.

Ports:
- clk1  in  1  single clock; every register updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- s_byte  in  8  incoming stream byte.
- s_valid  in  1  s_byte is valid.
- s_ready  out  1  loader accepts a byte; a transfer occurs when s_valid && s_ready at a rising edge.
- mem_we  out  1  one-cycle instruction memory write strobe.
- mem_addr  out  ADDR_W  word address for the write.
- mem_wdata  out  32  instruction word for the write.
- core_halt  out  1  holds the core halted (drives HALTED/stall).
- core_start  out  1  one-cycle pulse that clears PC and TAKEN_BRANCH and releases the core.
- busy  out  1  load in progress.
- done  out  1  load succeeded; sticky until rst.
- err  out  1  load failed; sticky until rst.

Behaviour:
- Reset values: s_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_halt=1, core_start=0, busy=0, done=0, err=0. The FSM enters LEN_HI, word count=0, byte index=0, checksum=0.
- Reset mid-load: all of the above apply on the next edge. Memory already written is not cleared. The next stream restarts at the length header.
- Stream format, in order:
  - 2-byte word count N, big-endian.
  - 4N payload bytes, each word MSB first.
  - 1 checksum byte equal to the XOR of all 4N payload bytes. The length bytes are excluded.
- States: LEN_HI, LEN_LO, WORD, CHK, RUN, ERR.
- s_ready=1 in LEN_HI, LEN_LO, WORD and CHK, with no internal backpressure. s_ready=0 in RUN and ERR. busy=1 in LEN_LO, WORD and CHK.
- LEN_HI: on a transfer, latch N[15:8] and go to LEN_LO. s_valid held low means the FSM idles here indefinitely.
- LEN_LO: on a transfer, latch N[7:0].
  - N==0 or N>MAX_WORDS: go to ERR.
  - Otherwise go to WORD.
- WORD:
  - Each transfer shifts the byte into a 32-bit packer and XORs it into the checksum.
  - On the 4th byte of a word, mem_we=1 on the following cycle, with mem_wdata = the packed word and mem_addr = the word index. The word index increments after the write.
  - The write cycle may coincide with acceptance of the next word's first byte; this is required to sustain 1 byte/cycle.
  - After word N-1 is packed, go to CHK.
  - Last-word case: mem_we for word N-1 is asserted in the first CHK cycle.
- CHK: on a transfer:
  - Byte == checksum: go to RUN, done=1, core_start=1 for exactly one cycle, core_halt=0 from the same cycle.
  - Byte != checksum: go to ERR, err=1, core_halt stays 1.
- RUN and ERR are terminal until rst. Bytes presented in these states are ignored (s_ready=0).
- Address wrap cannot occur because N ≤ MAX_WORDS ≤ 2**ADDR_W. mem_addr never exceeds N-1.
- Latency: last payload byte to its memory write is 1 cycle. Checksum byte to core_start is 1 cycle.

Decomposition:
- Shared package `boot_pkg`:
  - state encoding enum
  - LEN_BYTES=2, BYTES_PER_WORD=4
  - CHK_INIT=8'h00
- Sub-module `byte_word_packer`:
  - 2-bit byte counter and 32-bit shift register.
  - Outputs word_valid and word.
  - Has a clear input driven by rst.
  - The FSM owns the address, count and checksum logic.

Test Plan:
- Nominal load: stream 00 02 28 01 00 0a fc 00 00 00 DF at one byte per cycle → mem writes (0, 2801000a) and (1, fc000000); one core_start pulse; done=1; core_halt=0; s_ready=0 afterwards.
- Bad checksum: same stream ending in DE → both words written; err=1; core_start never asserted; core_halt=1; further bytes not accepted.
- Length bounds: header 00 00 → err after the 2nd byte, no mem_we. Header 04 01 with MAX_WORDS=1024 → err, no mem_we. Header 04 00 → accepted and enters WORD.
- Gapped valid: the nominal stream with s_valid toggled randomly → identical writes and result; no byte lost or duplicated.
- Reset mid-load: assert rst after 5 payload bytes, then send the full nominal stream → writes start again at address 0, done=1, exactly one core_start.
- Max size: N=MAX_WORDS with incrementing words → last write at address 1023; correct checksum gives done=1.
